// File: rtl/ddr_app_responder.sv
// ddr_app_responder: target end of the DDR3 controller app_* interface.
// A small 128-bit beat RAM answers write and read bursts. The block models
// calibration delay, command/write-data ready, optional write stalls and a
// fixed read latency, so initiators can run on an FPGA without the memory IP.
//
// Handshake rule used on every channel here: a transfer happens on a rising
// clk edge where both valid (app_cmd_en / app_wdata_en) and the matching
// ready (app_cmd_rdy / app_wdata_rdy) are high. Ready never depends
// combinationally on valid, because both ready outputs come straight from
// flops. The read channel has no ready: app_rdata_valid beats are pushed on
// consecutive cycles and the initiator must take them.
module ddr_app_responder #(
  parameter int          ADDR_BITS    = 8,        // log2 of beat storage depth
  parameter logic [15:0] CALIB_CYCLES = 16'd1000, // cycles until calibration completes
  parameter int          RD_LATENCY   = 4,        // accept -> first beat, legal 2..15
  parameter bit          STALL_EN     = 1'b0      // drop wdata_rdy every 4th WRITE cycle
) (
  input  logic         clk,
  input  logic         rstn,
  output logic         init_calib_complete,
  input  logic [5:0]   app_burst_number,
  input  logic [27:0]  app_addr,
  input  logic         app_cmd_en,
  input  logic [2:0]   app_cmd,
  output logic         app_cmd_rdy,
  input  logic         app_wdata_en,
  input  logic         app_wdata_end,
  input  logic [127:0] app_wdata,
  output logic         app_wdata_rdy,
  output logic         app_rdata_valid,
  output logic         app_rdata_end,
  output logic [127:0] app_rdata,
  output logic         proto_err
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  // Value of the latency counter in the cycle that issues the first RAM read;
  // the counter starts at 0 on the first RD_WAIT cycle.
  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 2);

  typedef enum logic [2:0] {
    S_CALIB   = 3'd0,
    S_IDLE    = 3'd1,
    S_WRITE   = 3'd2,
    S_RD_WAIT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  // FSM state and burst bookkeeping (state is kept as a plain named signal
  // so property checkers can bind to it directly).
  state_t                 state, state_d;
  logic [15:0]            calib_cnt, calib_cnt_d;
  logic                   calib_done, calib_done_d;
  logic [ADDR_BITS-1:0]   base, base_d;     // beat index of burst start
  logic [5:0]             last, last_d;     // burst length minus one
  logic [6:0]             beat, beat_d;     // beats accepted / reads issued so far
  logic [1:0]             wcnt, wcnt_d;     // cycles spent in WRITE, modulo 4
  logic [3:0]             lat, lat_d;       // cycles spent in RD_WAIT
  logic                   err, err_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   wdata_rdy_q, wdata_rdy_d;
  logic                   rvalid_q, rvalid_d;

  // RAM port controls
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic                   rd_en;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [127:0]           mem [DEPTH];
  logic [127:0]           rdata_q;

  // Decoded handshakes and command fields
  logic                   cmd_fire;
  logic                   wr_fire;
  logic                   cmd_is_wr;
  logic                   cmd_is_rd;
  logic [ADDR_BITS-1:0]   idx_in;
  logic [ADDR_BITS-1:0]   beat_off;
  logic                   addr_unused;

  assign cmd_fire  = app_cmd_en & cmd_rdy_q;
  assign wr_fire   = app_wdata_en & wdata_rdy_q;
  assign cmd_is_wr = (app_cmd == 3'h0);
  assign cmd_is_rd = (app_cmd == 3'h1);
  // One beat spans 8 columns, so the column bits below bit 3 are dropped.
  assign idx_in    = app_addr[ADDR_BITS+2:3];
  // Burst offsets wrap modulo the RAM depth through plain truncation.
  assign beat_off  = ADDR_BITS'(beat);
  // Column-within-beat and address bits above the RAM depth are don't-care.
  assign addr_unused = ^{app_addr[27:ADDR_BITS+3], app_addr[2:0]};

  // Next-state, RAM port control and next registered outputs.
  always_comb begin
    state_d      = state;
    calib_cnt_d  = calib_cnt;
    calib_done_d = calib_done;
    base_d       = base;
    last_d       = last;
    beat_d       = beat;
    wcnt_d       = wcnt;
    lat_d        = lat;
    err_d        = err;
    mem_we       = 1'b0;
    mem_waddr    = base + beat_off;
    rd_en        = 1'b0;
    rd_addr      = base + beat_off;

    case (state)
      S_CALIB: begin
        if (calib_cnt == CALIB_CYCLES - 16'd1) begin
          calib_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          calib_cnt_d = calib_cnt + 16'd1;
        end
      end

      S_IDLE: begin
        if (cmd_fire && cmd_is_wr) begin
          base_d  = idx_in;
          last_d  = app_burst_number;
          wcnt_d  = 2'd0;
          beat_d  = 7'd0;
          state_d = S_WRITE;
          // Beat 0 may ride along with the command.
          if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = idx_in;
            beat_d    = 7'd1;
            if (app_burst_number == 6'd0) begin
              state_d = S_IDLE;
            end
          end
        end else begin
          // A data beat with no write command has nowhere to go.
          if (wr_fire) begin
            err_d = 1'b1;
          end
          if (cmd_fire) begin
            if (cmd_is_rd) begin
              base_d  = idx_in;
              last_d  = app_burst_number;
              lat_d   = 4'd0;
              beat_d  = 7'd0;
              state_d = S_RD_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      S_WRITE: begin
        wcnt_d = wcnt + 2'd1;
        if (wr_fire) begin
          mem_we = 1'b1;
          beat_d = beat + 7'd1;
          if (beat == {1'b0, last}) begin
            state_d = S_IDLE;
          end
        end
      end

      S_RD_WAIT: begin
        lat_d = lat + 4'd1;
        // The read issued here lands on app_rdata one cycle later, which is
        // exactly RD_LATENCY cycles after the command was accepted.
        if (lat == LAT_LAST) begin
          rd_en   = 1'b1;
          rd_addr = base;
          beat_d  = 7'd1;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (beat <= {1'b0, last}) begin
          rd_en  = 1'b1;
          beat_d = beat + 7'd1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_CALIB;
      end
    endcase

    // Every accepted beat must carry app_wdata_end; the beat is still stored.
    if (wr_fire && !app_wdata_end) begin
      err_d = 1'b1;
    end

    cmd_rdy_d   = (state_d == S_IDLE);
    wdata_rdy_d = (state_d == S_IDLE) ||
                  ((state_d == S_WRITE) && !(STALL_EN && (wcnt_d == 2'd3)));
    rvalid_d    = rd_en;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_CALIB;
      calib_cnt   <= 16'd0;
      calib_done  <= 1'b0;
      base        <= '0;
      last        <= 6'd0;
      beat        <= 7'd0;
      wcnt        <= 2'd0;
      lat         <= 4'd0;
      err         <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      wdata_rdy_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state       <= state_d;
      calib_cnt   <= calib_cnt_d;
      calib_done  <= calib_done_d;
      base        <= base_d;
      last        <= last_d;
      beat        <= beat_d;
      wcnt        <= wcnt_d;
      lat         <= lat_d;
      err         <= err_d;
      cmd_rdy_q   <= cmd_rdy_d;
      wdata_rdy_q <= wdata_rdy_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Beat RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      mem[mem_waddr] <= app_wdata;
    end
  end

  // Synchronous RAM read port; its output register drives app_rdata.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  assign init_calib_complete = calib_done;
  assign app_cmd_rdy         = cmd_rdy_q;
  assign app_wdata_rdy       = wdata_rdy_q;
  assign app_rdata_valid     = rvalid_q;
  assign app_rdata_end       = rvalid_q;
  assign app_rdata           = rdata_q;
  assign proto_err           = err;

endmodule

// File: tb/tb_ddr_app_responder.sv
// tb_ddr_app_responder: directed bench for ddr_app_responder with a
// reference beat memory and an expected-read queue.
module tb_ddr_app_responder;

  localparam int          RD_LAT = 4;
  localparam logic [15:0] CAL    = 16'd20;

  logic         clk;
  logic         rstn;
  logic         app_init_calib_complete;
  logic [5:0]   app_burst_number;
  logic [27:0]  app_addr;
  logic         app_cmd_en;
  logic [2:0]   app_cmd;
  logic         app_cmd_rdy;
  logic         app_wdata_en;
  logic         app_wdata_end;
  logic [127:0] app_wdata;
  logic         app_wdata_rdy;
  logic         app_rdata_valid;
  logic         app_rdata_end;
  logic [127:0] app_rdata;
  logic         proto_err;

  ddr_app_responder #(
    .ADDR_BITS   (8),
    .CALIB_CYCLES(CAL),
    .RD_LATENCY  (RD_LAT),
    .STALL_EN    (1'b1)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .init_calib_complete(app_init_calib_complete),
    .app_burst_number   (app_burst_number),
    .app_addr           (app_addr),
    .app_cmd_en         (app_cmd_en),
    .app_cmd            (app_cmd),
    .app_cmd_rdy        (app_cmd_rdy),
    .app_wdata_en       (app_wdata_en),
    .app_wdata_end      (app_wdata_end),
    .app_wdata          (app_wdata),
    .app_wdata_rdy      (app_wdata_rdy),
    .app_rdata_valid    (app_rdata_valid),
    .app_rdata_end      (app_rdata_end),
    .app_rdata          (app_rdata),
    .proto_err          (proto_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [127:0] model [256];
  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           beats_seen = 0;
  logic [127:0] mon_d;
  int           mon_c;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-beat monitor: every valid beat must match the head of the queue.
  always @(negedge clk) begin
    if (app_rdata_valid === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("rdata_unexpected", 128'(app_rdata_valid), 128'd0);
      end else begin
        mon_d = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rdata", app_rdata, mon_d);
        check("rdata_cycle", 128'(cyc), 128'(mon_c));
        check("rdata_end", 128'(app_rdata_end), 128'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    app_cmd_en       = 1'b0;
    app_cmd          = 3'h0;
    app_addr         = 28'd0;
    app_burst_number = 6'd0;
    app_wdata_en     = 1'b0;
    app_wdata_end    = 1'b0;
    app_wdata        = 128'd0;
  endtask

  task automatic reset_and_calib();
    int r;
    int g;
    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_calib", 128'(app_init_calib_complete), 128'd0);
    check("rst_cmd_rdy", 128'(app_cmd_rdy), 128'd0);
    check("rst_wdata_rdy", 128'(app_wdata_rdy), 128'd0);
    check("rst_rvalid", 128'(app_rdata_valid), 128'd0);
    check("rst_rend", 128'(app_rdata_end), 128'd0);
    check("rst_proto_err", 128'(proto_err), 128'd0);
    check("rst_rdata", app_rdata, 128'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    r = cyc;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (app_init_calib_complete !== 1'b1 && g < 100);
    check("calib_latency", 128'(cyc - r), 128'(CAL));
    check("calib_cmd_rdy", 128'(app_cmd_rdy), 128'd1);
    check("calib_wdata_rdy", 128'(app_wdata_rdy), 128'd1);
  endtask

  task automatic write_burst(input logic [27:0] addr, input logic [5:0] b,
                             input logic [127:0] d0, output int cycles, output int stalls);
    int   sent;
    int   guard;
    bit   cmd_done;
    bit   cmd_acc;
    bit   dat_acc;
    logic [7:0] idx;
    sent = 0; guard = 0; cmd_done = 0; cycles = 0; stalls = 0;
    idx = addr[10:3];
    @(posedge clk);
    #1;
    app_cmd_en       = 1'b1;
    app_cmd          = 3'h0;
    app_addr         = addr;
    app_burst_number = b;
    app_wdata_en     = 1'b1;
    app_wdata_end    = 1'b1;
    app_wdata        = d0;
    while ((!cmd_done || sent <= int'(b)) && guard < 200) begin
      @(negedge clk);
      guard++;
      cmd_acc = app_cmd_en && app_cmd_rdy;
      dat_acc = app_wdata_en && app_wdata_rdy;
      if (cmd_done || cmd_acc) begin
        cycles++;
        if (!app_wdata_rdy) stalls++;
      end
      if (dat_acc) begin
        model[idx + 8'(sent)] = app_wdata;
        sent++;
      end
      if (cmd_acc) cmd_done = 1;
      @(posedge clk);
      #1;
      if (cmd_done) app_cmd_en = 1'b0;
      if (sent > int'(b)) begin
        app_wdata_en  = 1'b0;
        app_wdata_end = 1'b0;
      end else begin
        app_wdata = d0 + 128'(sent);
      end
    end
    check("write_beats", 128'(sent), 128'(b) + 128'd1);
    idle_inputs();
  endtask

  task automatic read_issue(input logic [27:0] addr, input logic [5:0] b, output int tacc);
    bit   acc;
    int   guard;
    logic [7:0] idx;
    acc = 0; guard = 0; tacc = 0;
    idx = addr[10:3];
    @(posedge clk);
    #1;
    app_cmd_en       = 1'b1;
    app_cmd          = 3'h1;
    app_addr         = addr;
    app_burst_number = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      guard++;
      if (app_cmd_rdy === 1'b1) begin
        acc  = 1;
        tacc = cyc;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("read_accept", 128'(acc), 128'd1);
    if (acc) begin
      for (int n = 0; n <= int'(b); n++) begin
        exp_q.push_back(model[idx + 8'(n)]);
        exp_cyc_q.push_back(tacc + RD_LAT + n);
      end
    end
  endtask

  task automatic read_burst(input logic [27:0] addr, input logic [5:0] b);
    int tacc;
    int guard;
    read_issue(addr, b, tacc);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("read_drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic idle_pulse(input logic cen, input logic [2:0] cmd,
                            input logic wen, input logic [127:0] data);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    app_cmd_en    = cen;
    app_cmd       = cmd;
    app_wdata_en  = wen;
    app_wdata_end = wen;
    app_wdata     = data;
    do begin
      @(negedge clk);
      guard++;
    end while (!(cen ? app_cmd_rdy : app_wdata_rdy) && guard < 100);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    int stalls;
    int tacc;
    int bs0;
    rstn = 1'b0;
    idle_inputs();

    reset_and_calib();

    // Basic 4-beat write, beat 0 with the command, then read back.
    write_burst(28'h0, 6'd3, 128'h0123456789abcdeffedcba9876543210, cycles, stalls);
    check("wr4_cycles", 128'(cycles), 128'd4);
    check("wr4_stalls", 128'(stalls), 128'd0);
    read_burst(28'h0, 6'd3);

    // Fence beat at index 24, then an 8-beat stalled write at index 16;
    // a 9-beat read shows exactly 8 beats were written.
    write_burst(28'hC0, 6'd0, 128'hfeedface_00000000_cafef00d_00000018, cycles, stalls);
    check("wr1_cycles", 128'(cycles), 128'd1);
    write_burst(28'h80, 6'd7, 128'h55aa55aa_00000000_11111111_00000000, cycles, stalls);
    check("wr8_cycles", 128'(cycles), 128'd10);
    check("wr8_stalls", 128'(stalls), 128'd2);
    read_burst(28'h80, 6'd8);

    // Wrap: beat 1 of a burst starting at index 255 lands at index 0.
    write_burst(28'h7F8, 6'd1, 128'hdeadbeef_0000ffff_12345678_9abcdef0, cycles, stalls);
    read_burst(28'h0, 6'd0);
    read_burst(28'h7F8, 6'd1);
    @(negedge clk);
    check("proto_err_clean", 128'(proto_err), 128'd0);

    // Illegal command, then a stray write beat in IDLE.
    idle_pulse(1'b1, 3'h2, 1'b0, 128'd0);
    @(negedge clk);
    check("illegal_proto_err", 128'(proto_err), 128'd1);
    check("illegal_stay_idle", 128'(app_cmd_rdy), 128'd1);
    idle_pulse(1'b0, 3'h0, 1'b1, 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0);
    @(negedge clk);
    check("stray_proto_err", 128'(proto_err), 128'd1);
    read_burst(28'h0, 6'd3);
    @(negedge clk);
    check("sticky_proto_err", 128'(proto_err), 128'd1);

    // Reset during the 2nd beat of a 4-beat read.
    bs0 = beats_seen;
    read_issue(28'h0, 6'd3, tacc);
    while (cyc < tacc + RD_LAT + 1) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("beats_before_reset", 128'(beats_seen - bs0), 128'd2);
    exp_q.delete();
    exp_cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rvalid_after_reset", 128'(app_rdata_valid), 128'd0);
    end
    reset_and_calib();
    read_burst(28'h0, 6'd3);
    read_burst(28'h80, 6'd7);

    repeat (3) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_app_responder.md
Name: ddr_app_responder

Overview:
- Synthesizable responder model of the DDR3 controller user (app) interface; the target end of the app_* handshake that bare_tester-style initiators drive.
- Holds a small on-chip RAM of 128-bit beats, so testers and traffic generators run on the FPGA without the memory IP.
- Emulates calibration delay, command/write-data ready handshakes, optional write backpressure, and fixed-latency burst read return.

Parameters:
- ADDR_BITS, 8, log2 of beat storage depth (256 x 128 bit).
- CALIB_CYCLES, 16'd1000, cycles after reset release before init_calib_complete rises.
- RD_LATENCY, 4, cycles from read-command accept to first rdata beat; legal range 2..15.
- STALL_EN, 0, 1 = drop app_wdata_rdy on every 4th cycle spent in WRITE.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous and active-low.
- init_calib_complete  out  1  calibration done.
- app_burst_number  in  6  burst length minus one (B means B+1 beats).
- app_addr  in  28  start address, column-granular; 1 beat = 8 columns.
- app_cmd_en  in  1  command valid.
- app_cmd  in  3  3'h0 write, 3'h1 read, others illegal.
- app_cmd_rdy  out  1  command accepted when app_cmd_en & app_cmd_rdy.
- app_wdata_en  in  1  write beat valid.
- app_wdata_end  in  1  marks a beat; must equal app_wdata_en.
- app_wdata  in  128  write beat.
- app_wdata_rdy  out  1  write beat accepted when app_wdata_en & app_wdata_rdy.
- app_rdata_valid  out  1  read beat valid.
- app_rdata_end  out  1  asserted with every valid read beat.
- app_rdata  out  128  read beat.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rstn low at a clk edge): state CALIB; calib counter 0; init_calib_complete, app_cmd_rdy, app_wdata_rdy, app_rdata_valid, app_rdata_end, proto_err = 0; app_rdata = 0. RAM contents are not cleared. Reset mid-burst aborts the burst; no partial read beats follow.
- Beat index = app_addr[ADDR_BITS+2:3]. Beat n of a burst uses index+n, modulo 2^ADDR_BITS (wraps). app_addr[2:0] and upper bits are ignored.
- CALIB: counter increments every cycle. On reaching CALIB_CYCLES-1: init_calib_complete <= 1 (then held until reset) and state -> IDLE.
- IDLE: app_cmd_rdy = 1, app_wdata_rdy = 1 (both registered).
- Write command accepted in IDLE:
  - Latch index and beat count B+1; state -> WRITE.
  - A write beat valid in the same cycle is accepted as beat 0.
  - If B = 0 and beat 0 arrives with the command, return directly to IDLE.
- Write beat in IDLE without a write command: ignored; proto_err <= 1.
- WRITE:
  - app_cmd_rdy = 0. app_wdata_rdy = 1, except when STALL_EN = 1 and the 2-bit WRITE cycle counter (cleared on entry) = 3.
  - Each accepted beat is written to RAM that cycle; it is readable by a read command accepted the next cycle.
  - After beat B is accepted: state -> IDLE; ready signals high on the following cycle.
  - app_cmd_en in WRITE is ignored; it is not an error, since the initiator must wait for app_cmd_rdy.
- Read command accepted in IDLE:
  - Latch index and B; state -> RD_WAIT; app_cmd_rdy = 0, app_wdata_rdy = 0.
  - Accepted at cycle T: first beat valid at T+RD_LATENCY, followed by B further beats on consecutive cycles.
  - app_rdata_valid = app_rdata_end = 1 for every beat.
  - Beat data comes from synchronous RAM reads issued one cycle before each output beat.
  - After the last beat: valid = 0 next cycle; state -> IDLE.
- Illegal app_cmd accepted in IDLE: no operation; proto_err <= 1; stays IDLE.
- app_wdata_end != app_wdata_en on an accepted beat: proto_err <= 1; beat still written.
- No command is accepted before init_calib_complete.
- Bursts are non-overlapping: one command in flight at a time.

Test Plan:
- Reset, CALIB_CYCLES = 20 -> init_calib_complete rises exactly 20 cycles after rstn release; app_cmd_rdy and app_wdata_rdy rise together with it.
- Write B = 3 at addr 0, beat 0 sent with the command, data 0x0123..3210 + n; then read B = 3 at addr 0 -> with RD_LATENCY = 4, beats valid on cycles T+4..T+7, data n = 0..3 matches, rdata_end high on each.
- STALL_EN = 1, write B = 7 with wdata_en held high -> app_wdata_rdy low on every 4th WRITE cycle; exactly 8 beats stored; readback matches.
- Write B = 1 at beat index 255 (addr 0x7F8) -> second beat lands at index 0; read at addr 0 returns it.
- Illegal cmd 3'h2, and a stray wdata_en in IDLE -> no RAM change; proto_err = 1 until reset.
- Assert rstn low during the 2nd beat of a B = 3 read -> rdata_valid = 0 the next cycle and stays 0; calibration repeats; earlier RAM data still reads back correctly.
